// File: rtl/rgb_overlay_pkg.sv
// Shared mode encodings and marker colours for the RGB marker overlay stage.
// Colours are full-scale per channel, so the datapath only needs a 3-bit on/off mask per pixel.
package rgb_overlay_pkg;

    localparam int COLOR_W = 8;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_MARK   = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_BARS   = 2'd3
    } mode_t;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    localparam rgb_t BLACK = '{r: '0, g: '0, b: '0};
    localparam rgb_t RED   = '{r: '1, g: '0, b: '0};
    localparam rgb_t GREEN = '{r: '0, g: '1, b: '0};
    localparam rgb_t BLUE  = '{r: '0, g: '0, b: '1};
    localparam rgb_t WHITE = '{r: '1, g: '1, b: '1};

    // Collapse a full-scale colour into an {R,G,B} on/off mask so it can be
    // re-expanded to any channel width.
    function automatic logic [2:0] rgb_mask(input rgb_t c);
        return {&c.r, &c.g, &c.b};
    endfunction

endpackage

// File: rtl/rgb_frame_ctrl.sv
// Per-frame state: latches the requested mode and advances the blink phase on each valid sof.
// Next-state values are exported so the sof pixel itself already sees the new frame settings.
module rgb_frame_ctrl
    import rgb_overlay_pkg::*;
#(
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_valid,
    input  logic       i_sof,
    input  logic [1:0] i_mode,
    output mode_t      mode_nxt,
    output logic       blink_on_nxt
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    mode_t            mode_q;
    logic [CNT_W-1:0] blink_cnt;
    logic             blink_on;
    logic [CNT_W-1:0] blink_cnt_nxt;
    logic             frame_start;

    assign frame_start = i_valid && i_sof;

    always_comb begin
        mode_nxt      = mode_q;
        blink_cnt_nxt = blink_cnt;
        blink_on_nxt  = blink_on;
        if (frame_start) begin
            mode_nxt = mode_t'(i_mode);
            if (blink_cnt == CNT_LAST) begin
                blink_cnt_nxt = '0;
                blink_on_nxt  = ~blink_on;
            end else begin
                blink_cnt_nxt = blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= MODE_BYPASS;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            mode_q    <= mode_nxt;
            blink_cnt <= blink_cnt_nxt;
            blink_on  <= blink_on_nxt;
        end
    end

endmodule

// File: rtl/rgb_marker_overlay.sv
// Two-stage RGB post-process: corner calibration markers, window clamp and colour bars.
// Stage 1 registers region flags and frame settings; stage 2 selects the output colour.
module rgb_marker_overlay
    import rgb_overlay_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int COORD_W      = 13,
    parameter int ACTIVE_W     = 617,
    parameter int ACTIVE_H     = 478,
    parameter int MARK_SIZE    = 5,
    parameter int BLINK_FRAMES = 30,
    parameter int BAR_SHIFT    = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_valid,
    input  logic               i_sof,
    input  logic [COORD_W-1:0] i_row,
    input  logic [COORD_W-1:0] i_col,
    input  logic [DATA_W-1:0]  i_R,
    input  logic [DATA_W-1:0]  i_G,
    input  logic [DATA_W-1:0]  i_B,
    input  logic [1:0]         i_mode,
    output logic               o_valid,
    output logic               o_sof,
    output logic [DATA_W-1:0]  o_R,
    output logic [DATA_W-1:0]  o_G,
    output logic [DATA_W-1:0]  o_B
);

    localparam logic [COORD_W-1:0] ROW_END  = COORD_W'(ACTIVE_H);
    localparam logic [COORD_W-1:0] COL_END  = COORD_W'(ACTIVE_W);
    localparam logic [COORD_W-1:0] MARK_LIM = COORD_W'(MARK_SIZE);
    localparam logic [COORD_W-1:0] ROW_HI   = COORD_W'(ACTIVE_H - MARK_SIZE);
    localparam logic [COORD_W-1:0] COL_HI   = COORD_W'(ACTIVE_W - MARK_SIZE);

    mode_t mode_nxt;
    logic  blink_on_nxt;

    rgb_frame_ctrl #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_frame (
        .clk          (clk),
        .reset        (reset),
        .i_valid      (i_valid),
        .i_sof        (i_sof),
        .i_mode       (i_mode),
        .mode_nxt     (mode_nxt),
        .blink_on_nxt (blink_on_nxt)
    );

    logic row_lo, row_hi, col_lo, col_hi, oob;

    always_comb begin
        row_lo = i_row < MARK_LIM;
        row_hi = i_row >= ROW_HI;
        col_lo = i_col < MARK_LIM;
        col_hi = i_col >= COL_HI;
        oob    = (i_row >= ROW_END) || (i_col >= COL_END);
    end

    logic              s1_valid, s1_sof, s1_blink;
    logic              s1_oob, s1_tl, s1_tr, s1_bl, s1_br;
    logic [2:0]        s1_bar;
    logic [DATA_W-1:0] s1_r, s1_g, s1_b;
    mode_t             s1_mode;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_blink <= 1'b0;
            s1_oob   <= 1'b0;
            s1_tl    <= 1'b0;
            s1_tr    <= 1'b0;
            s1_bl    <= 1'b0;
            s1_br    <= 1'b0;
            s1_bar   <= '0;
            s1_r     <= '0;
            s1_g     <= '0;
            s1_b     <= '0;
            s1_mode  <= MODE_BYPASS;
        end else begin
            s1_valid <= i_valid;
            s1_sof   <= i_sof;
            s1_blink <= blink_on_nxt;
            s1_oob   <= oob;
            s1_tl    <= row_lo && col_lo;
            s1_tr    <= row_lo && col_hi;
            s1_bl    <= row_hi && col_lo;
            s1_br    <= row_hi && col_hi;
            s1_bar   <= i_col[BAR_SHIFT+2:BAR_SHIFT];
            s1_r     <= i_R;
            s1_g     <= i_G;
            s1_b     <= i_B;
            s1_mode  <= mode_nxt;
        end
    end

    // Every generated colour is full-scale per channel, so stage 2 picks either
    // a 3-bit mask or the raw pixel.
    logic              markers_on, use_mask;
    logic [2:0]        mask;
    logic [DATA_W-1:0] px_r, px_g, px_b;

    always_comb begin
        markers_on = (s1_mode == MODE_MARK) || ((s1_mode == MODE_BLINK) && s1_blink);
        use_mask   = 1'b1;
        mask       = rgb_mask(BLACK);
        if (s1_oob) begin
            mask = rgb_mask(BLACK);
        end else if (s1_mode == MODE_BARS) begin
            mask = s1_bar;
        end else if (markers_on && s1_tl) begin
            mask = rgb_mask(RED);
        end else if (markers_on && s1_tr) begin
            mask = rgb_mask(GREEN);
        end else if (markers_on && s1_bl) begin
            mask = rgb_mask(BLUE);
        end else if (markers_on && s1_br) begin
            mask = rgb_mask(WHITE);
        end else begin
            use_mask = 1'b0;
        end

        if (!s1_valid) begin
            px_r = '0;
            px_g = '0;
            px_b = '0;
        end else if (use_mask) begin
            px_r = {DATA_W{mask[2]}};
            px_g = {DATA_W{mask[1]}};
            px_b = {DATA_W{mask[0]}};
        end else begin
            px_r = s1_r;
            px_g = s1_g;
            px_b = s1_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            o_R     <= '0;
            o_G     <= '0;
            o_B     <= '0;
        end else begin
            o_valid <= s1_valid;
            o_sof   <= s1_sof;
            o_R     <= px_r;
            o_G     <= px_g;
            o_B     <= px_b;
        end
    end

endmodule
